// File: rtl/cv32e40p_alu_fault_tracker_ft.sv
// Per-unit, per-class ALU error tracker: a leaky counter per class raises a sticky permanent-fault flag.
// Optional macro FT_ALU_ERR_DECAY_EN enables the decrement of a counter on error-free operations.
module cv32e40p_alu_fault_tracker_ft #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_CLASSES = 9,
    parameter int CNT_W       = 8,
    parameter int THRESHOLD   = 100,
    parameter int DEC_STEP    = 2,
    parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_UNITS-1:0]                    valid_i,
    input  logic [NUM_UNITS-1:0][CLS_W-1:0]         class_i,
    input  logic [NUM_UNITS-1:0]                    error_i,
    input  logic                                    clear_i,
    output logic [NUM_UNITS-1:0][NUM_CLASSES-1:0]   faulty_o,
    output logic [NUM_UNITS-1:0]                    unit_faulty_o,
    output logic [NUM_UNITS-1:0]                    new_fault_o
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (THRESHOLD < 1 || THRESHOLD > CNT_MAX || DEC_STEP < 1) begin : g_bad_params
        $error("cv32e40p_alu_fault_tracker_ft: THRESHOLD must be in [1, 2^CNT_W-1] and DEC_STEP >= 1");
    end

    logic [NUM_UNITS-1:0][NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_UNITS-1:0][NUM_CLASSES-1:0]            faulty_q, faulty_d;
    logic [NUM_UNITS-1:0]                             new_q, new_d;

    // valid_i[u] qualifies class_i[u]/error_i[u] for a single cycle; there is no back-pressure.
    // Each unit touches at most one class per cycle, so units never contend for a counter.
    always_comb begin
        logic [CLS_W-1:0] cls;
        int               cur;
        int               nxt;
        cnt_d    = cnt_q;
        faulty_d = faulty_q;
        new_d    = '0;
        cls      = '0;
        cur      = 0;
        nxt      = 0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            cls = class_i[u];
            if (valid_i[u] && (32'(cls) < NUM_CLASSES) && !faulty_q[u][cls]) begin
                cur = 32'(cnt_q[u][cls]);
                if (error_i[u]) begin
                    nxt = (cur >= CNT_MAX) ? CNT_MAX : cur + 1;
                end else begin
`ifdef FT_ALU_ERR_DECAY_EN
                    nxt = (cur > DEC_STEP) ? cur - DEC_STEP : 0;
`else
                    nxt = cur;
`endif
                end
                // Crossing the threshold retires the class: flag latches and its counter parks at 0.
                if (nxt >= THRESHOLD) begin
                    faulty_d[u][cls] = 1'b1;
                    cnt_d[u][cls]    = '0;
                    new_d[u]         = 1'b1;
                end else begin
                    cnt_d[u][cls] = CNT_W'(nxt);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            faulty_q <= '0;
            new_q    <= '0;
        end else if (clear_i) begin
            cnt_q    <= '0;
            faulty_q <= '0;
            new_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            faulty_q <= faulty_d;
            new_q    <= new_d;
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_faulty_o[u] = |faulty_q[u];
        end
    end

    assign faulty_o    = faulty_q;
    assign new_fault_o = new_q;

endmodule

// File: tb/tb_cv32e40p_alu_fault_tracker_ft.sv
// Directed bench for cv32e40p_alu_fault_tracker_ft at default parameters (4 units, 9 classes, threshold 100).
module tb_cv32e40p_alu_fault_tracker_ft;

    logic                  clk;
    logic                  rst;
    logic [3:0]            valid_i;
    logic [3:0][3:0]       class_i;
    logic [3:0]            error_i;
    logic                  clear_i;
    logic [3:0][8:0]       faulty_o;
    logic [3:0]            unit_faulty_o;
    logic [3:0]            new_fault_o;

    int n_tests = 0;
    int n_fail  = 0;

    cv32e40p_alu_fault_tracker_ft dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .class_i       (class_i),
        .error_i       (error_i),
        .clear_i       (clear_i),
        .faulty_o      (faulty_o),
        .unit_faulty_o (unit_faulty_o),
        .new_fault_o   (new_fault_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard check
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] fbit(input int u, input int c);
        logic [35:0] r;
        r = '0;
        r[u*9 + c] = 1'b1;
        return r;
    endfunction

    task automatic check_out(input string tag, input logic [35:0] f, input logic [3:0] uf,
                             input logic [3:0] nf);
        check_eq({tag, ".faulty"}, 64'(faulty_o), 64'(f));
        check_eq({tag, ".unit_faulty"}, 64'(unit_faulty_o), 64'(uf));
        check_eq({tag, ".new_fault"}, 64'(new_fault_o), 64'(nf));
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = '0;
        class_i = '0;
        error_i = '0;
        clear_i = 1'b0;
    endtask

    task automatic ev(input int u, input int c, input logic e, input int n);
        logic [3:0] cv;
        cv = 4'(c);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            valid_i[u] = 1'b1;
            class_i[u] = cv;
            error_i[u] = e;
            tick();
        end
        idle_inputs();
    endtask

    task automatic do_clear();
        idle_inputs();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", '0, 4'b0000, 4'b0000);
        rst = 1'b0;

        // 100 consecutive errors on unit 0 class 3
        ev(0, 3, 1'b1, 99);
        check_out("u0c3_99", '0, 4'b0000, 4'b0000);
        ev(0, 3, 1'b1, 1);
        check_out("u0c3_100", fbit(0, 3), 4'b0001, 4'b0001);
        tick();
        check_out("u0c3_after", fbit(0, 3), 4'b0001, 4'b0000);
        ev(0, 3, 1'b1, 5);
        check_out("u0c3_sticky", fbit(0, 3), 4'b0001, 4'b0000);
        do_clear();
        check_out("clear1", '0, 4'b0000, 4'b0000);

        // all units valid together, only unit 2 erroring
        for (int i = 0; i < 100; i++) begin
            valid_i = 4'b1111;
            class_i[0] = 4'd1;
            class_i[1] = 4'd2;
            class_i[2] = 4'd7;
            class_i[3] = 4'd4;
            error_i = 4'b0100;
            tick();
            if (i == 98) check_out("par_99", '0, 4'b0000, 4'b0000);
        end
        idle_inputs();
        check_out("par_100", fbit(2, 7), 4'b0100, 4'b0100);
        ev(3, 12, 1'b1, 100);
        check_out("cls12", fbit(2, 7), 4'b0100, 4'b0000);
        do_clear();

        // asynchronous reset mid-cycle
        ev(0, 5, 1'b1, 60);
        ev(1, 0, 1'b1, 100);
        check_out("pre_rst", fbit(1, 0), 4'b0010, 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", '0, 4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
        ev(0, 5, 1'b1, 99);
        check_out("post_rst_99", '0, 4'b0000, 4'b0000);
        ev(0, 5, 1'b1, 1);
        check_out("post_rst_100", fbit(0, 5), 4'b0001, 4'b0001);
        do_clear();

        // clear coincident with the 100th error
        ev(0, 2, 1'b1, 99);
        valid_i[0] = 1'b1;
        class_i[0] = 4'd2;
        error_i[0] = 1'b1;
        clear_i    = 1'b1;
        tick();
        idle_inputs();
        check_out("clr_same", '0, 4'b0000, 4'b0000);
        ev(0, 2, 1'b1, 99);
        check_out("clr_recount_99", '0, 4'b0000, 4'b0000);
        ev(0, 2, 1'b1, 1);
        check_out("clr_recount_100", fbit(0, 2), 4'b0001, 4'b0001);
        do_clear();
        ev(0, 2, 1'b1, 100);
        check_out("reflag", fbit(0, 2), 4'b0001, 4'b0001);
        do_clear();

`ifdef FT_ALU_ERR_DECAY_EN
        // 50 errors, 10 clean (-20) leaves 30; 70 more errors reach 100
        ev(1, 0, 1'b1, 50);
        ev(1, 0, 1'b0, 10);
        ev(1, 0, 1'b1, 69);
        check_out("decay_69", '0, 4'b0000, 4'b0000);
        ev(1, 0, 1'b1, 1);
        check_out("decay_70", fbit(1, 0), 4'b0010, 4'b0010);
        do_clear();
        // 3 -> 1 -> 0 (floor, no wrap), then a full 100 are needed
        ev(2, 8, 1'b1, 3);
        ev(2, 8, 1'b0, 2);
        ev(2, 8, 1'b1, 99);
        check_out("floor_99", '0, 4'b0000, 4'b0000);
        ev(2, 8, 1'b1, 1);
        check_out("floor_100", fbit(2, 8), 4'b0100, 4'b0100);
        do_clear();
`else
        // without decay, clean events leave the counter alone
        ev(1, 0, 1'b1, 50);
        ev(1, 0, 1'b0, 1000);
        ev(1, 0, 1'b1, 49);
        check_out("nodecay_99", '0, 4'b0000, 4'b0000);
        ev(1, 0, 1'b1, 1);
        check_out("nodecay_100", fbit(1, 0), 4'b0010, 4'b0010);
        do_clear();
`endif

        check_out("final", '0, 4'b0000, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
